// File: rtl/tlb_refill_ctrl_pkg.sv
// Shared definitions for the TLB refill controller: exception codes, table bases, FSM states.
// Optional round-robin tie arbitration is enabled with the TLB_REFILL_RR_EN macro.
package tlb_refill_ctrl_pkg;

   localparam logic [31:0] EXC_ITLB_MISS = 32'd12;
   localparam logic [31:0] EXC_DTLB_MISS = 32'd13;

   localparam logic [31:0] ITLB_BASE_ADDRESS_SHIFT_CORE0 = 32'h0000_8000;
   localparam logic [31:0] DTLB_BASE_ADDRESS_SHIFT_CORE0 = 32'h0000_C000;

   // src encoding used throughout: 0 = ITLB, 1 = DTLB
   localparam logic SRC_ITLB = 1'b0;
   localparam logic SRC_DTLB = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   function automatic logic [31:0] exc_of(input logic src);
      return (src == SRC_DTLB) ? EXC_DTLB_MISS : EXC_ITLB_MISS;
   endfunction

endpackage

// File: rtl/tlb_refill_addr_gen.sv
// PTE address generation: table base of the requesting TLB plus the page index scaled to 4-byte entries.
// Carry out of the top bit is dropped (modulo 2^ADDR_W).
module tlb_refill_addr_gen
   import tlb_refill_ctrl_pkg::*;
#(
   parameter int              ADDR_W     = 32,
   parameter int              PAGE_SHIFT = 12,
   parameter logic [ADDR_W-1:0] ITLB_BASE = ADDR_W'(ITLB_BASE_ADDRESS_SHIFT_CORE0),
   parameter logic [ADDR_W-1:0] DTLB_BASE = ADDR_W'(DTLB_BASE_ADDRESS_SHIFT_CORE0)
) (
   input  logic              src,
   input  logic [ADDR_W-1:0] vaddr,
   output logic [ADDR_W-1:0] pte_addr
);

   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] index;

   always_comb begin
      base     = (src == SRC_DTLB) ? DTLB_BASE : ITLB_BASE;
      index    = (vaddr >> PAGE_SHIFT) << 2;
      pte_addr = base + index;
   end

endmodule

// File: rtl/tlb_refill_ctrl.sv
// TLB refill sequencer: arbitrates ITLB/DTLB misses and runs one PTE read on the shared memory port.
// Define TLB_REFILL_RR_EN for round-robin on simultaneous misses; otherwise DTLB has fixed priority.
module tlb_refill_ctrl
   import tlb_refill_ctrl_pkg::*;
#(
   parameter int              ADDR_W     = 32,
   parameter int              PAGE_SHIFT = 12,
   parameter logic [ADDR_W-1:0] ITLB_BASE = ADDR_W'(32'h0000_8000),
   parameter logic [ADDR_W-1:0] DTLB_BASE = ADDR_W'(32'h0000_C000)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              itlb_miss_i,
   input  logic [ADDR_W-1:0] itlb_vaddr_i,
   input  logic              dtlb_miss_i,
   input  logic [ADDR_W-1:0] dtlb_vaddr_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [ADDR_W-1:0] mem_rdata_i,
   output logic              itlb_done_o,
   output logic              dtlb_done_o,
   output logic [ADDR_W-1:0] pte_o,
   output logic              fault_o,
   output logic [31:0]       exc_code_o,
   output logic              busy_o
);

   state_t            state;
   logic              src_q;
   logic [ADDR_W-1:0] vaddr_q;
   logic [ADDR_W-1:0] addr_calc;
   logic              grant_dtlb;

`ifdef TLB_REFILL_RR_EN
   // Remembers who won the last tie; cleared so DTLB takes the first tie.
   logic last_dtlb_q;

   assign grant_dtlb = dtlb_miss_i & (~itlb_miss_i | ~last_dtlb_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_dtlb_q <= 1'b0;
      end else if (state == ST_IDLE && itlb_miss_i && dtlb_miss_i) begin
         last_dtlb_q <= grant_dtlb;
      end
   end
`else
   assign grant_dtlb = dtlb_miss_i;
`endif

   tlb_refill_addr_gen #(
      .ADDR_W     (ADDR_W),
      .PAGE_SHIFT (PAGE_SHIFT),
      .ITLB_BASE  (ITLB_BASE),
      .DTLB_BASE  (DTLB_BASE)
   ) u_addr_gen (
      .src      (src_q),
      .vaddr    (vaddr_q),
      .pte_addr (addr_calc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         src_q       <= SRC_ITLB;
         vaddr_q     <= '0;
         mem_req_o   <= 1'b0;
         mem_addr_o  <= '0;
         itlb_done_o <= 1'b0;
         dtlb_done_o <= 1'b0;
         pte_o       <= '0;
         fault_o     <= 1'b0;
         exc_code_o  <= '0;
         busy_o      <= 1'b0;
      end else begin
         itlb_done_o <= 1'b0;
         dtlb_done_o <= 1'b0;
         fault_o     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (itlb_miss_i || dtlb_miss_i) begin
                  src_q      <= grant_dtlb;
                  vaddr_q    <= grant_dtlb ? dtlb_vaddr_i : itlb_vaddr_i;
                  exc_code_o <= exc_of(grant_dtlb);
                  busy_o     <= 1'b1;
                  state      <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               mem_addr_o <= addr_calc;
               mem_req_o  <= 1'b1;
               state      <= ST_ISSUE;
            end
            ST_ISSUE: begin
               if (mem_gnt_i) begin
                  mem_req_o <= 1'b0;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid_i) begin
                  pte_o       <= mem_rdata_i;
                  fault_o     <= ~mem_rdata_i[0];
                  itlb_done_o <= (src_q == SRC_ITLB);
                  dtlb_done_o <= (src_q == SRC_DTLB);
                  state       <= ST_RESP;
               end
            end
            ST_RESP: begin
               exc_code_o <= '0;
               busy_o     <= 1'b0;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Self-checking bench for tlb_refill_ctrl: directed refills, scoreboard queues checked by a monitor.
// Expectations for repeated ties follow TLB_REFILL_RR_EN when that macro is defined.
module tb_tlb_refill_ctrl;
   import tlb_refill_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        itlb_miss_i, dtlb_miss_i;
   logic [31:0] itlb_vaddr_i, dtlb_vaddr_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        itlb_done_o, dtlb_done_o;
   logic [31:0] pte_o;
   logic        fault_o;
   logic [31:0] exc_code_o;
   logic        busy_o;

`ifdef TLB_REFILL_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   tlb_refill_ctrl dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .itlb_miss_i  (itlb_miss_i),
      .itlb_vaddr_i (itlb_vaddr_i),
      .dtlb_miss_i  (dtlb_miss_i),
      .dtlb_vaddr_i (dtlb_vaddr_i),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .itlb_done_o  (itlb_done_o),
      .dtlb_done_o  (dtlb_done_o),
      .pte_o        (pte_o),
      .fault_o      (fault_o),
      .exc_code_o   (exc_code_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [67:0] exp_q[$];       // {itlb_done, dtlb_done, fault, busy, exc, pte}
   logic [31:0] exp_addr_q[$];
   logic [31:0] mem_data_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic push_refill(input bit d, input logic [31:0] addr, input logic [31:0] pte);
      exp_addr_q.push_back(addr);
      mem_data_q.push_back(pte);
      exp_q.push_back({~d, d, ~pte[0], 1'b1, (d ? EXC_DTLB_MISS : EXC_ITLB_MISS), pte});
   endtask

   // ---------------- memory responder ----------------
   int gnt_delay = 0;
   int rv_delay  = 0;
   bit early_rv  = 0;

   initial begin
      int wait_cnt = 0;
      int rv_cnt = 0;
      bit rv_pending = 0;
      logic [31:0] rv_data = '0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
      forever begin
         @(negedge clk);
         mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
         if (rv_pending) begin
            if (rv_cnt == 0) begin
               mem_rvalid_i = 1; mem_rdata_i = rv_data; rv_pending = 0;
            end else begin
               rv_cnt--;
            end
         end else if (mem_req_o) begin
            if (wait_cnt >= gnt_delay) begin
               mem_gnt_i = 1; wait_cnt = 0; rv_pending = 1; rv_cnt = rv_delay;
               rv_data = (mem_data_q.size() != 0) ? mem_data_q.pop_front() : 32'h0;
            end else begin
               wait_cnt++;
               if (early_rv && wait_cnt == 2) begin
                  mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
               end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      logic prev_req = 0;
      logic [31:0] prev_addr = '0;
      forever begin
         @(posedge clk); #2;
         if (reset_n) begin
            if (mem_req_o && !prev_req) begin
               if (exp_addr_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_req: got addr %h, none expected", mem_addr_o);
               end else begin
                  check("pte_addr", 68'(mem_addr_o), 68'(exp_addr_q.pop_front()));
               end
            end else if (mem_req_o && prev_req) begin
               check("addr_stable", 68'({mem_req_o, mem_addr_o}), 68'({1'b1, prev_addr}));
            end
            if (itlb_done_o || dtlb_done_o) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_done: got itlb=%b dtlb=%b pte=%h, none expected",
                           itlb_done_o, dtlb_done_o, pte_o);
               end else begin
                  check("done_resp", {itlb_done_o, dtlb_done_o, fault_o, busy_o, exc_code_o, pte_o},
                        exp_q.pop_front());
               end
            end
         end
         prev_req  = mem_req_o;
         prev_addr = mem_addr_o;
      end
   end

   // ---------------- driver ----------------
   // Runs until both misses are dropped and the controller is idle; misses drop on their done pulse.
   task automatic run_refills(input int max_cyc, output int first_lat, output int idle_gap);
      int cyc = 0;
      int dones = 0;
      bit ok = 0;
      first_lat = -1; idle_gap = 0;
      while (cyc < max_cyc) begin
         @(negedge clk); cyc++;
         if (itlb_done_o || dtlb_done_o) begin
            dones++;
            if (dones == 1) first_lat = cyc;
         end else if (dones == 1 && !busy_o && (itlb_miss_i || dtlb_miss_i)) begin
            idle_gap++;
         end
         if (itlb_done_o) itlb_miss_i = 0;
         if (dtlb_done_o) dtlb_miss_i = 0;
         if (!itlb_miss_i && !dtlb_miss_i && !busy_o) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         $display("FAIL run_timeout: got no completion in %0d cycles, required completion", max_cyc);
         itlb_miss_i = 0; dtlb_miss_i = 0;
      end
   endtask

   task automatic check_quiet(input string name);
      check(name, 68'({mem_req_o, itlb_done_o, dtlb_done_o, fault_o, busy_o, exc_code_o}), 68'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, gap;
      reset_n = 0; itlb_miss_i = 0; dtlb_miss_i = 0;
      itlb_vaddr_i = '0; dtlb_vaddr_i = '0;
      repeat (3) @(negedge clk);
      check_quiet("rst_ctrl");
      check("rst_addr", 68'(mem_addr_o), 68'(0));
      check("rst_pte", 68'(pte_o), 68'(0));
      reset_n = 1;
      @(negedge clk);

      // single ITLB refill, zero-wait memory
      push_refill(0, 32'h0000_8048, 32'hABCD_E001);
      itlb_vaddr_i = 32'h0001_2345; itlb_miss_i = 1;
      run_refills(40, lat, gap);
      check("t1_latency", 68'(lat), 68'(4));
      check_quiet("t1_idle");

      // two ties in a row
      for (int r = 0; r < 2; r++) begin
         if (RR && r == 1) begin
            push_refill(0, 32'h0000_8014, 32'h2222_3001);
            push_refill(1, 32'h0000_C00C, 32'h1111_2001);
         end else begin
            push_refill(1, 32'h0000_C00C, 32'h1111_2001);
            push_refill(0, 32'h0000_8014, 32'h2222_3001);
         end
         dtlb_vaddr_i = 32'h0000_3000; itlb_vaddr_i = 32'h0000_5000;
         dtlb_miss_i = 1; itlb_miss_i = 1;
         run_refills(60, lat, gap);
         check("t2_first_latency", 68'(lat), 68'(4));
         check("t2_idle_gap", 68'(gap), 68'(1));
      end

      // grant withheld 5 cycles, stray rvalid while issuing
      gnt_delay = 5; early_rv = 1;
      push_refill(1, 32'h0000_C01C, 32'h5555_5001);
      dtlb_vaddr_i = 32'h0000_7000; dtlb_miss_i = 1;
      run_refills(60, lat, gap);
      check("t3_latency", 68'(lat), 68'(9));
      gnt_delay = 0; early_rv = 0;

      // invalid PTE faults; top-of-range vaddr
      push_refill(1, 32'h0040_BFFC, 32'h0000_0000);
      dtlb_vaddr_i = 32'hFFFF_F000; dtlb_miss_i = 1;
      run_refills(40, lat, gap);
      check("t4_latency", 68'(lat), 68'(4));

      // reset while waiting for read data, late rvalid afterwards
      rv_delay = 4;
      exp_addr_q.push_back(32'h0000_8048);
      mem_data_q.push_back(32'h7777_7001);
      itlb_vaddr_i = 32'h0001_2345; itlb_miss_i = 1;
      begin
         int n = 0;
         do begin @(negedge clk); n++; end while (!mem_req_o && n < 20);
         do begin @(negedge clk); n++; end while (mem_req_o && n < 40);
         check("t5_reached_wait", 68'({busy_o, mem_req_o}), 68'(2'b10));
      end
      reset_n = 0; itlb_miss_i = 0;
      @(negedge clk);
      check_quiet("t5_in_reset");
      check("t5_pte_cleared", 68'({mem_addr_o, pte_o}), 68'(0));
      reset_n = 1;
      repeat (8) @(negedge clk);
      check_quiet("t5_after_late_rvalid");
      rv_delay = 0;

      check("exp_q_empty", 68'(exp_q.size()), 68'(0));
      check("exp_addr_q_empty", 68'(exp_addr_q.size()), 68'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
